bp_me_burst_mem_responder: RTL and testbench



---
 rtl/bp_me_burst_mem_responder_pkg.sv | 46 ++++
 rtl/bp_me_burst_mem_storage.sv | 32 +++
 rtl/bp_me_burst_mem_responder.sv | 199 +++++++++++++++++++
 tb/tb_bp_me_burst_mem_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_burst_mem_responder_pkg.sv
// Shared BedRock memory-interface types for the burst responder and its users.
// Holds the mem header layout, the msg_type and size encodings, and small decode helpers.
// Header field order (MSB..LSB): msg_type, addr, size, payload.
package bp_me_burst_mem_responder_pkg;

  localparam int bedrock_paddr_width_gp   = 40;
  localparam int bedrock_payload_width_gp = 16;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_amo   = 4'd4
  } bp_bedrock_mem_type_e;

  // size encodes a transfer of 2^size bytes
  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    bp_bedrock_mem_type_e                msg_type;
    logic [bedrock_paddr_width_gp-1:0]   addr;
    bp_bedrock_msg_size_e                size;
    logic [bedrock_payload_width_gp-1:0] payload;
  } bp_bedrock_mem_header_s;

  localparam int bedrock_mem_header_width_gp = $bits(bp_bedrock_mem_header_s);

  function automatic logic is_read_msg(input logic [3:0] msg_type);
    return (msg_type == e_bedrock_mem_rd) || (msg_type == e_bedrock_mem_uc_rd);
  endfunction

  function automatic logic is_write_msg(input logic [3:0] msg_type);
    return (msg_type == e_bedrock_mem_wr) || (msg_type == e_bedrock_mem_uc_wr);
  endfunction

endpackage

// File: rtl/bp_me_burst_mem_storage.sv
// Word-addressed storage array: one shared read/write port, byte-masked writes.
// Latency: read is combinational on addr_i; write lands on the rising edge.
// Backpressure: none; always accepts. Contents are not reset.
// Ports: clk_i; w_i write enable; addr_i word index; data_i/mask_i write data and
//        byte enables; data_o word currently addressed.
module bp_me_burst_mem_storage #(
  parameter int width_p = 64,
  parameter int els_p   = 1024,
  localparam int lg_els_lp = $clog2(els_p),
  localparam int bytes_lp  = width_p / 8
) (
  input  logic                 clk_i,
  input  logic                 w_i,
  input  logic [lg_els_lp-1:0] addr_i,
  input  logic [width_p-1:0]   data_i,
  input  logic [bytes_lp-1:0]  mask_i,
  output logic [width_p-1:0]   data_o
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge clk_i) begin
    if (w_i) begin
      for (int b = 0; b < bytes_lp; b++) begin
        if (mask_i[b]) mem[addr_i][8*b +: 8] <= data_i[8*b +: 8];
      end
    end
  end

  assign data_o = mem[addr_i];

endmodule

// File: rtl/bp_me_burst_mem_responder.sv
// BedRock burst memory responder: serves mem_cmd (header + write beats) from local storage.
// Latency: read resp header 1 cycle after cmd header, beats follow back-to-back; write resp 1 cycle after last beat.
// Backpressure: ready/valid on every channel; outputs hold while stalled, one transaction in flight.
// Ports: clk_i, reset_n_i (async active-low); mem_cmd header/data in with ready_and out;
//        mem_resp header/data out with ready_and in; error_o sticky on bad msg_type or oversize.
module bp_me_burst_mem_responder
  import bp_me_burst_mem_responder_pkg::*;
#(
  parameter int paddr_width_p   = 40,
  parameter int data_width_p    = 64,
  parameter int block_width_p   = 512,
  parameter int payload_width_p = 16,
  parameter int mem_els_p       = 1024,
  localparam int hdr_width_lp   = 4 + paddr_width_p + 3 + payload_width_p
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,

  input  logic [hdr_width_lp-1:0] mem_cmd_header_i,
  input  logic                    mem_cmd_header_v_i,
  output logic                    mem_cmd_header_ready_and_o,
  input  logic [data_width_p-1:0] mem_cmd_data_i,
  input  logic                    mem_cmd_data_v_i,
  output logic                    mem_cmd_data_ready_and_o,

  output logic [hdr_width_lp-1:0] mem_resp_header_o,
  output logic                    mem_resp_header_v_o,
  input  logic                    mem_resp_header_ready_and_i,
  output logic [data_width_p-1:0] mem_resp_data_o,
  output logic                    mem_resp_data_v_o,
  input  logic                    mem_resp_data_ready_and_i,

  output logic                    error_o
);

  localparam int data_bytes_lp    = data_width_p / 8;
  localparam int lg_data_bytes_lp = $clog2(data_bytes_lp);
  localparam int lg_els_lp        = $clog2(mem_els_p);
  localparam int max_beats_lp     = block_width_p / data_width_p;
  localparam int cnt_width_lp     = $clog2(max_beats_lp) + 1;
  localparam int max_size_lp      = $clog2(block_width_p / 8);

  localparam int size_lsb_lp = payload_width_p;
  localparam int addr_lsb_lp = size_lsb_lp + 3;
  localparam int msg_lsb_lp  = addr_lsb_lp + paddr_width_p;

  typedef enum logic [2:0] {
    e_reset, e_ready, e_wr_data, e_wr_resp, e_rd_resp, e_rd_data
  } state_e;

  state_e                   state_r;
  logic                     hdr_ready_r, data_ready_r, resp_hdr_v_r, resp_data_v_r, error_r;
  logic [hdr_width_lp-1:0]  hdr_r;
  logic [2:0]               size_r;   // clamped size of the latched transaction
  logic [cnt_width_lp-1:0]  cnt_r;

  // Incoming header decode, only meaningful in e_ready
  logic [3:0] in_msg;
  logic [2:0] in_size;
  logic       in_oversize;
  assign in_msg      = mem_cmd_header_i[msg_lsb_lp +: 4];
  assign in_size     = mem_cmd_header_i[size_lsb_lp +: 3];
  assign in_oversize = in_size > 3'(max_size_lp);

  // Beat geometry of the latched transaction
  logic [cnt_width_lp-1:0]     last_cnt;
  logic [lg_els_lp-1:0]        base_idx, beat_mask, word_idx;
  logic [lg_data_bytes_lp-1:0] byte_off;
  logic [data_bytes_lp-1:0]    byte_mask;
  logic                        last_beat;

  always_comb begin
    last_cnt  = '0;
    byte_off  = '0;
    byte_mask = '1;
    if (size_r > 3'(lg_data_bytes_lp)) begin
      last_cnt = cnt_width_lp'((32'd1 << (size_r - 3'(lg_data_bytes_lp))) - 32'd1);
    end
    if (size_r < 3'(lg_data_bytes_lp)) begin
      // Sub-word access: enable only the 2^size bytes at the size-aligned offset
      byte_off  = hdr_r[addr_lsb_lp +: lg_data_bytes_lp]
                  & ~lg_data_bytes_lp'((32'd1 << size_r) - 32'd1);
      byte_mask = (~({data_bytes_lp{1'b1}} << (32'd1 << size_r))) << byte_off;
    end
    base_idx  = hdr_r[addr_lsb_lp + lg_data_bytes_lp +: lg_els_lp];
    beat_mask = lg_els_lp'(last_cnt);
    // Wrap inside the size-aligned block so the addressed word comes out first
    word_idx  = (base_idx & ~beat_mask) | ((base_idx + lg_els_lp'(cnt_r)) & beat_mask);
    last_beat = (cnt_r == last_cnt);
  end

  logic store_w;
  assign store_w = data_ready_r & mem_cmd_data_v_i;

  bp_me_burst_mem_storage #(
    .width_p (data_width_p),
    .els_p   (mem_els_p)
  ) storage (
    .clk_i  (clk_i),
    .w_i    (store_w),
    .addr_i (word_idx),
    .data_i (mem_cmd_data_i),
    .mask_i (byte_mask),
    .data_o (mem_resp_data_o)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r       <= e_reset;
      hdr_ready_r   <= 1'b0;
      data_ready_r  <= 1'b0;
      resp_hdr_v_r  <= 1'b0;
      resp_data_v_r <= 1'b0;
      error_r       <= 1'b0;
      hdr_r         <= '0;
      size_r        <= '0;
      cnt_r         <= '0;
    end else begin
      case (state_r)
        e_reset: begin
          state_r     <= e_ready;
          hdr_ready_r <= 1'b1;
        end
        e_ready: begin
          if (hdr_ready_r && mem_cmd_header_v_i) begin
            hdr_r       <= mem_cmd_header_i;
            size_r      <= in_oversize ? 3'(max_size_lp) : in_size;
            cnt_r       <= '0;
            hdr_ready_r <= 1'b0;
            if (in_oversize) error_r <= 1'b1;
            if (is_read_msg(in_msg)) begin
              state_r      <= e_rd_resp;
              resp_hdr_v_r <= 1'b1;
            end else if (is_write_msg(in_msg)) begin
              state_r      <= e_wr_data;
              data_ready_r <= 1'b1;
            end else begin
              // Unsupported op: acknowledge with a header only, storage untouched
              state_r      <= e_wr_resp;
              resp_hdr_v_r <= 1'b1;
              error_r      <= 1'b1;
            end
          end
        end
        e_wr_data: begin
          if (mem_cmd_data_v_i) begin
            if (last_beat) begin
              state_r      <= e_wr_resp;
              data_ready_r <= 1'b0;
              resp_hdr_v_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + 1'b1;
            end
          end
        end
        e_wr_resp: begin
          if (mem_resp_header_ready_and_i) begin
            state_r      <= e_ready;
            resp_hdr_v_r <= 1'b0;
            hdr_ready_r  <= 1'b1;
          end
        end
        e_rd_resp: begin
          if (mem_resp_header_ready_and_i) begin
            state_r       <= e_rd_data;
            resp_hdr_v_r  <= 1'b0;
            resp_data_v_r <= 1'b1;
          end
        end
        e_rd_data: begin
          if (mem_resp_data_ready_and_i) begin
            if (last_beat) begin
              state_r       <= e_ready;
              resp_data_v_r <= 1'b0;
              hdr_ready_r   <= 1'b1;
            end else begin
              cnt_r <= cnt_r + 1'b1;
            end
          end
        end
        default: begin
          state_r       <= e_ready;
          hdr_ready_r   <= 1'b1;
          data_ready_r  <= 1'b0;
          resp_hdr_v_r  <= 1'b0;
          resp_data_v_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_cmd_header_ready_and_o = hdr_ready_r;
  assign mem_cmd_data_ready_and_o   = data_ready_r;
  assign mem_resp_header_o          = hdr_r;
  assign mem_resp_header_v_o        = resp_hdr_v_r;
  assign mem_resp_data_v_o          = resp_data_v_r;
  assign error_o                    = error_r;

endmodule

// File: tb/tb_bp_me_burst_mem_responder.sv
// Directed bench for bp_me_burst_mem_responder: writes, wrapped reads, sub-word writes,
// stalled reads, unsupported ops, oversize reads and mid-burst reset, checked against
// a word-array model through header/beat scoreboards.
module tb_bp_me_burst_mem_responder;
  import bp_me_burst_mem_responder_pkg::*;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  bp_bedrock_mem_header_s mem_cmd_header_i, mem_resp_header_o;
  logic        mem_cmd_header_v_i, mem_cmd_header_ready_and_o;
  logic [63:0] mem_cmd_data_i;
  logic        mem_cmd_data_v_i, mem_cmd_data_ready_and_o;
  logic        mem_resp_header_v_o, mem_resp_header_ready_and_i;
  logic [63:0] mem_resp_data_o;
  logic        mem_resp_data_v_o, mem_resp_data_ready_and_i;
  logic        error_o;

  bp_me_burst_mem_responder dut (
    .clk_i                       (clk_i),
    .reset_n_i                   (reset_n_i),
    .mem_cmd_header_i            (mem_cmd_header_i),
    .mem_cmd_header_v_i          (mem_cmd_header_v_i),
    .mem_cmd_header_ready_and_o  (mem_cmd_header_ready_and_o),
    .mem_cmd_data_i              (mem_cmd_data_i),
    .mem_cmd_data_v_i            (mem_cmd_data_v_i),
    .mem_cmd_data_ready_and_o    (mem_cmd_data_ready_and_o),
    .mem_resp_header_o           (mem_resp_header_o),
    .mem_resp_header_v_o         (mem_resp_header_v_o),
    .mem_resp_header_ready_and_i (mem_resp_header_ready_and_i),
    .mem_resp_data_o             (mem_resp_data_o),
    .mem_resp_data_v_o           (mem_resp_data_v_o),
    .mem_resp_data_ready_and_i   (mem_resp_data_ready_and_i),
    .error_o                     (error_o)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [63:0]            model [1024];
  bp_bedrock_mem_header_s exp_hdr_q [$];
  logic [63:0]            exp_data_q [$];
  logic [63:0]            wr_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int n_beats(input logic [2:0] size);
    int s;
    s = (size > 3'd6) ? 6 : int'(size);
    return (s > 3) ? (1 << (s - 3)) : 1;
  endfunction

  // Word touched by beat k: wrap inside the aligned group of n words
  function automatic int word_of(input logic [39:0] addr, input logic [2:0] size, input int k);
    int idx, n;
    idx = int'(addr[12:3]);
    n   = n_beats(size);
    return (idx / n) * n + ((idx % n) + k) % n;
  endfunction

  function automatic bp_bedrock_mem_header_s make_hdr(input logic [3:0] msg, input logic [39:0] addr,
                                                      input logic [2:0] size, input logic [15:0] payload);
    bp_bedrock_mem_header_s h;
    h.msg_type = bp_bedrock_mem_type_e'(msg);
    h.addr     = addr;
    h.size     = bp_bedrock_msg_size_e'(size);
    h.payload  = payload;
    return h;
  endfunction

  // All drive/sample activity happens at negedges; a transfer occurs at the posedge that follows
  task automatic send_hdr(input bp_bedrock_mem_header_s h);
    int guard = 0;
    mem_cmd_header_i   = h;
    mem_cmd_header_v_i = 1'b1;
    while (!mem_cmd_header_ready_and_o && guard < 100) begin @(negedge clk_i); guard++; end
    check("cmd_hdr_ready", 64'(mem_cmd_header_ready_and_o), 64'd1);
    check("no_data_ready_with_hdr", 64'(mem_cmd_data_ready_and_o), 64'd0);
    @(negedge clk_i);
    mem_cmd_header_v_i = 1'b0;
  endtask

  task automatic send_data(input logic [63:0] beat);
    int guard = 0;
    mem_cmd_data_i   = beat;
    mem_cmd_data_v_i = 1'b1;
    while (!mem_cmd_data_ready_and_o && guard < 100) begin @(negedge clk_i); guard++; end
    check("cmd_data_ready", 64'(mem_cmd_data_ready_and_o), 64'd1);
    @(negedge clk_i);
    mem_cmd_data_v_i = 1'b0;
  endtask

  task automatic recv_hdr(input string tag, input bit stall);
    int guard = 0;
    bp_bedrock_mem_header_s e, seen;
    e = exp_hdr_q.pop_front();
    mem_resp_header_ready_and_i = 1'b0;
    while (!mem_resp_header_v_o && guard < 100) begin @(negedge clk_i); guard++; end
    check({tag, "_v"}, 64'(mem_resp_header_v_o), 64'd1);
    check({tag, "_lat"}, 64'(guard), 64'd0);
    seen = mem_resp_header_o;
    check(tag, 64'(seen), 64'(e));
    if (stall) begin
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk_i);
        check({tag, "_hold"}, 64'({mem_resp_header_v_o, mem_resp_header_o}), 64'({1'b1, seen}));
      end
    end
    mem_resp_header_ready_and_i = 1'b1;
    @(negedge clk_i);
    mem_resp_header_ready_and_i = 1'b0;
  endtask

  task automatic recv_beat(input string tag, input bit stall);
    int guard = 0;
    logic [63:0] e, seen;
    e = exp_data_q.pop_front();
    mem_resp_data_ready_and_i = 1'b0;
    while (!mem_resp_data_v_o && guard < 100) begin @(negedge clk_i); guard++; end
    check({tag, "_v"}, 64'(mem_resp_data_v_o), 64'd1);
    check({tag, "_lat"}, 64'(guard), 64'd0);
    seen = mem_resp_data_o;
    check(tag, seen, e);
    if (stall) begin
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk_i);
        check({tag, "_hold_v"}, 64'(mem_resp_data_v_o), 64'd1);
        check({tag, "_hold"}, mem_resp_data_o, seen);
      end
    end
    mem_resp_data_ready_and_i = 1'b1;
    @(negedge clk_i);
    mem_resp_data_ready_and_i = 1'b0;
  endtask

  // Beats to write are taken from wr_q; the first one is presented before the header
  task automatic do_write(input logic [3:0] msg, input logic [39:0] addr, input logic [2:0] size,
                          input logic [15:0] payload);
    bp_bedrock_mem_header_s h;
    logic [63:0] beat;
    int w, off, nb;
    h = make_hdr(msg, addr, size, payload);
    exp_hdr_q.push_back(h);
    mem_cmd_data_i   = wr_q[0];
    mem_cmd_data_v_i = 1'b1;
    send_hdr(h);
    for (int k = 0; k < n_beats(size); k++) begin
      beat = wr_q.pop_front();
      w    = word_of(addr, size, k);
      if (size < 3'd3) begin
        nb  = 1 << size;
        off = (int'(addr[2:0]) / nb) * nb;
        for (int b = off; b < off + nb; b++) model[w][8*b +: 8] = beat[8*b +: 8];
      end else begin
        model[w] = beat;
      end
      send_data(beat);
    end
    recv_hdr("wr_resp_hdr", 1'b0);
  endtask

  task automatic do_read(input string tag, input logic [3:0] msg, input logic [39:0] addr,
                         input logic [2:0] size, input logic [15:0] payload, input bit stall, input int take);
    bp_bedrock_mem_header_s h;
    h = make_hdr(msg, addr, size, payload);
    exp_hdr_q.push_back(h);
    for (int k = 0; k < n_beats(size); k++) exp_data_q.push_back(model[word_of(addr, size, k)]);
    send_hdr(h);
    recv_hdr({tag, "_hdr"}, stall ? 1'($urandom_range(0, 1)) : 1'b0);
    for (int k = 0; k < take; k++) recv_beat({tag, "_beat"}, stall ? 1'($urandom_range(0, 1)) : 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_cmd_header_i            = '0;
    mem_cmd_header_v_i          = 1'b0;
    mem_cmd_data_i              = '0;
    mem_cmd_data_v_i            = 1'b0;
    mem_resp_header_ready_and_i = 1'b0;
    mem_resp_data_ready_and_i   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("reset_outs", 64'({mem_cmd_header_ready_and_o, mem_cmd_data_ready_and_o,
                            mem_resp_header_v_o, mem_resp_data_v_o, error_o}), 64'd0);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    check("ready_after_reset", 64'(mem_cmd_header_ready_and_o), 64'd1);

    // 64B write to 0x80 then read it back in order
    for (int k = 0; k < 8; k++) wr_q.push_back(64'hC0DE_0000_0000_0000 | 64'(k));
    do_write(e_bedrock_mem_wr, 40'h80, 3'd6, 16'h0001);
    do_read("rd80", e_bedrock_mem_rd, 40'h80, 3'd6, 16'h0002, 1'b0, 8);
    check("error_clean", 64'(error_o), 64'd0);

    // Critical word first: 0x98 is word 3 of the block
    do_read("rd98", e_bedrock_mem_rd, 40'h98, 3'd6, 16'h0003, 1'b0, 8);

    // Single-byte uncached write into lane 5, then an 8B uncached read of the word
    wr_q.push_back(64'hFFFF_ABFF_FFFF_FFFF);
    do_write(e_bedrock_mem_uc_wr, 40'h85, 3'd0, 16'h0004);
    do_read("ucrd80", e_bedrock_mem_uc_rd, 40'h80, 3'd3, 16'h0005, 1'b0, 1);
    check("ucrd_one_beat", 64'(mem_resp_data_v_o), 64'd0);

    // Randomly stalled 64B read
    do_read("stall80", e_bedrock_mem_rd, 40'h80, 3'd6, 16'h0006, 1'b1, 8);
    check("stall_eight_beats", 64'(mem_resp_data_v_o), 64'd0);
    check("stall_back_ready", 64'(mem_cmd_header_ready_and_o), 64'd1);

    // Unsupported msg_type: header-only response, storage unchanged, sticky error
    exp_hdr_q.push_back(make_hdr(4'd4, 40'h80, 3'd3, 16'h1234));
    send_hdr(make_hdr(4'd4, 40'h80, 3'd3, 16'h1234));
    recv_hdr("amo_hdr", 1'b0);
    check("amo_no_data", 64'(mem_resp_data_v_o), 64'd0);
    check("amo_error", 64'(error_o), 64'd1);
    do_read("post_amo", e_bedrock_mem_rd, 40'h80, 3'd6, 16'h0007, 1'b0, 8);
    check("error_sticky", 64'(error_o), 64'd1);

    // Reset after 3 of 8 read beats
    do_read("rst_rd", e_bedrock_mem_rd, 40'h80, 3'd6, 16'h0008, 1'b0, 3);
    reset_n_i = 1'b0;
    #1;
    check("midreset_outs", 64'({mem_cmd_header_ready_and_o, mem_cmd_data_ready_and_o,
                               mem_resp_header_v_o, mem_resp_data_v_o, error_o}), 64'd0);
    exp_data_q.delete();
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    check("ready_after_midreset", 64'(mem_cmd_header_ready_and_o), 64'd1);
    check("no_stale_data", 64'(mem_resp_data_v_o), 64'd0);
    do_read("rd88", e_bedrock_mem_rd, 40'h88, 3'd3, 16'h0009, 1'b0, 1);
    check("rd88_one_beat", 64'(mem_resp_data_v_o), 64'd0);
    check("error_cleared", 64'(error_o), 64'd0);

    // Oversize request clamps to the 64B block and flags an error
    do_read("rd_size7", e_bedrock_mem_rd, 40'h90, 3'd7, 16'h000A, 1'b0, 8);
    check("size7_done", 64'(mem_resp_data_v_o), 64'd0);
    check("size7_error", 64'(error_o), 64'd1);

    check("scoreboard_empty", 64'(exp_hdr_q.size() + exp_data_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
